// File: rtl/sdram_log_writer.sv
// Telemetry logger feeding sdram_interface: buffers samples in a small FIFO,
// prefixes each frame with a two-word timestamp header, writes words linearly.
module sdram_log_writer #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter bit          WRAP_EN    = 1'b0,
  parameter logic [7:0]  HDR_TAG    = 8'hA5
) (
  input  logic        CLK_48MHZ,
  input  logic        NSYSRESET,
  input  logic [23:0] TIMESTAMP,
  input  logic        FRAME_START,
  input  logic [15:0] SAMPLE_DATA,
  input  logic        SAMPLE_VALID,
  output logic        SAMPLE_READY,
  input  logic [1:0]  SDRAM_STATUS,
  output logic [1:0]  CMD_OUT,
  output logic [1:0]  BANK_OUT,
  output logic [12:0] ROW_OUT,
  output logic [8:0]  COL_OUT,
  output logic [15:0] DATA_OUT,
  output logic [23:0] WORDS_WRITTEN,
  output logic        FULL,
  output logic        OVERFLOW
);
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C  = (PW+1)'(FIFO_DEPTH);
  localparam logic [1:0]  CMD_IDLE = 2'b00;
  localparam logic [1:0]  CMD_WR   = 2'b01;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, FULL_ST} state_t;
  typedef enum logic [1:0] {SRC_DATA, SRC_HDR0, SRC_HDR1} src_t;

  logic [15:0]   mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          ready_q, ready_d, ovf_q, ovf_d;
  logic [23:0]   hdr_ts_q, hdr_ts_d;
  logic          hdr_pending_q, hdr_pending_d, hdr_phase_q, hdr_phase_d;
  src_t          src_q, src_d;
  state_t        state_q, state_d;
  logic [1:0]    cmd_q, cmd_d;
  logic [23:0]   addr_q, addr_d;
  logic [15:0]   data_q, data_d;
  logic [23:0]   words_q, words_d;
  logic          full_q, full_d;
  logic          push, pop, accept, fifo_full, fifo_empty;

  assign fifo_full  = (count_q == DEPTH_C);
  assign fifo_empty = (count_q == '0);
  assign accept     = (state_q == ISSUE) && SDRAM_STATUS[0];
  // READY is registered, so a push is refused on a full FIFO even if a pop happens now
  assign push       = SAMPLE_VALID && ready_q;
  assign pop        = accept && (src_q == SRC_DATA);

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
    ready_d  = (count_d != DEPTH_C);
    ovf_d    = ovf_q | (SAMPLE_VALID & fifo_full);
  end

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    addr_d        = addr_q;
    data_d        = data_q;
    words_d       = words_q;
    full_d        = full_q;
    src_d         = src_q;
    hdr_pending_d = hdr_pending_q;
    hdr_phase_d   = hdr_phase_q;
    hdr_ts_d      = FRAME_START ? TIMESTAMP : hdr_ts_q;
    unique case (state_q)
      IDLE: begin
        if (hdr_pending_q) begin
          src_d   = hdr_phase_q ? SRC_HDR1 : SRC_HDR0;
          data_d  = hdr_phase_q ? hdr_ts_q[15:0] : {HDR_TAG, hdr_ts_q[23:16]};
          cmd_d   = CMD_WR;
          state_d = ISSUE;
        end else if (!fifo_empty) begin
          src_d   = SRC_DATA;
          data_d  = mem_q[rd_ptr_q];
          cmd_d   = CMD_WR;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (SDRAM_STATUS[0]) begin
          cmd_d   = CMD_IDLE;
          state_d = WAIT_DONE;
          if (src_q == SRC_HDR0) hdr_phase_d = 1'b1;
          if (src_q == SRC_HDR1) begin
            hdr_pending_d = 1'b0;
            hdr_phase_d   = 1'b0;
          end
        end
      end
      WAIT_DONE: begin
        if (SDRAM_STATUS[1]) begin
          if (words_q != 24'hFFFFFF) words_d = words_q + 24'd1;
          if (addr_q != 24'hFFFFFF) begin
            addr_d  = addr_q + 24'd1;
            state_d = IDLE;
          end else if (WRAP_EN) begin
            addr_d  = '0;
            state_d = IDLE;
          end else begin
            full_d  = 1'b1;
            state_d = FULL_ST;
          end
        end
      end
      FULL_ST: cmd_d = CMD_IDLE;
    endcase
    // A new frame start wins over a header completing in the same cycle
    if (FRAME_START) hdr_pending_d = 1'b1;
  end

  always_ff @(posedge CLK_48MHZ) begin
    if (push) mem_q[wr_ptr_q] <= SAMPLE_DATA;
    hdr_ts_q <= hdr_ts_d;
  end

  always_ff @(posedge CLK_48MHZ or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      ready_q       <= 1'b0;
      ovf_q         <= 1'b0;
      hdr_pending_q <= 1'b0;
      hdr_phase_q   <= 1'b0;
      src_q         <= SRC_DATA;
      state_q       <= IDLE;
      cmd_q         <= CMD_IDLE;
      addr_q        <= '0;
      data_q        <= '0;
      words_q       <= '0;
      full_q        <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      ready_q       <= ready_d;
      ovf_q         <= ovf_d;
      hdr_pending_q <= hdr_pending_d;
      hdr_phase_q   <= hdr_phase_d;
      src_q         <= src_d;
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      words_q       <= words_d;
      full_q        <= full_d;
    end
  end

  // Linear address: bank/row/col concatenated, so a plain increment walks col, row, bank
  assign BANK_OUT      = addr_q[23:22];
  assign ROW_OUT       = addr_q[21:9];
  assign COL_OUT       = addr_q[8:0];
  assign CMD_OUT       = cmd_q;
  assign DATA_OUT      = data_q;
  assign WORDS_WRITTEN = words_q;
  assign FULL          = full_q;
  assign OVERFLOW      = ovf_q;
  assign SAMPLE_READY  = ready_q;
endmodule

// File: doc/sdram_log_writer.md
Name: sdram_log_writer

Overview:
- Upstream feeder for sdram_interface. Accepts 16-bit telemetry samples from the sensor pipeline and buffers them in an 8-deep FIFO.
- Inserts a two-word timestamp header at each frame start.
- Issues single-word write commands (CMD_IN, A_IN_BANK/ROW/COL, D_IN) to sdram_interface at a linearly incrementing address until the memory is full.

Parameters:
- FIFO_DEPTH, 8, sample buffer depth in words (power of 2).
- WRAP_EN, 0, 1 = address wraps to 0 when memory is full; 0 = stop and assert FULL.
- HDR_TAG, 8'hA5, upper byte of header word 0.

Ports:
- CLK_48MHZ  in  1  system clock, 48 MHz.
- NSYSRESET  in  1  asynchronous active-low reset.
- TIMESTAMP  in  24  free-running timestamp.
- FRAME_START  in  1  one-cycle pulse; next write begins with a header.
- SAMPLE_DATA  in  16  sample word.
- SAMPLE_VALID  in  1  sample present.
- SAMPLE_READY  out  1  FIFO can accept; high when FIFO not full.
- SDRAM_STATUS  in  2  from sdram_interface STATUS: [0] READY (idle, accepts command), [1] WR_DONE (one-cycle pulse at write completion).
- CMD_OUT  out  2  to CMD_IN: 00 idle, 01 write.
- BANK_OUT  out  2  to A_IN_BANK.
- ROW_OUT  out  13  to A_IN_ROW.
- COL_OUT  out  9  to A_IN_COL.
- DATA_OUT  out  16  to D_IN.
- WORDS_WRITTEN  out  24  count of completed writes, saturating.
- FULL  out  1  memory full (WRAP_EN=0 only).
- OVERFLOW  out  1  sticky; sample offered while FIFO full.

Behaviour:
- Reset (async assert, sync release), all outputs 0:
  - CMD_OUT=00; address = 0; DATA_OUT=0; WORDS_WRITTEN=0.
  - FULL=0; OVERFLOW=0; FIFO empty; header pending=0.
  - SAMPLE_READY=0 while NSYSRESET low, 1 from the first clock after release.
- FIFO:
  - Push when SAMPLE_VALID & SAMPLE_READY.
  - Pop only in ISSUE data-word acceptance.
  - Push and pop in the same cycle when full: the push is refused (READY reflects pre-pop state); no data loss on the pop side.
  - SAMPLE_VALID while full sets OVERFLOW. OVERFLOW clears only on reset.
- Header capture:
  - FRAME_START latches TIMESTAMP into hdr_ts and sets hdr_pending.
  - A second FRAME_START before the header is issued re-latches the timestamp; only one header is written.
- Address:
  - Linear order: COL 0..511, then ROW++ (COL=0), then BANK++ (ROW=0) after row 8191.
  - Increment only on WR_DONE.
  - After bank 3/row 8191/col 511 completes: WRAP_EN=1 gives address 0; WRAP_EN=0 sets FULL, and the FSM enters FULL_ST permanently until reset.
- FSM states: IDLE, ISSUE, WAIT_DONE, FULL_ST.
  - IDLE: source select with priority (1) hdr_pending, giving HDR0 word {HDR_TAG, hdr_ts[23:16]}, then HDR1 word hdr_ts[15:0]; (2) FIFO non-empty, giving the FIFO head. Load DATA_OUT and go to ISSUE.
  - ISSUE: drive CMD_OUT=01 with address/data stable.
    - When SDRAM_STATUS[0]=1 in this cycle, the command is accepted: CMD_OUT returns to 00 next cycle and the state goes to WAIT_DONE.
    - FIFO pops at acceptance only for a data word.
    - hdr_pending clears when HDR1 is accepted.
    - HDR0 and HDR1 are always consecutive, with no data word between them.
  - WAIT_DONE: hold address/data; on WR_DONE increment the address and WORDS_WRITTEN, then go to IDLE (or FULL_ST).
  - WR_DONE outside WAIT_DONE is ignored.
  - FULL_ST: CMD_OUT=00; FIFO keeps accepting until full, then OVERFLOW as normal.
- Latency: with READY=1 and WR_DONE two cycles after acceptance, a sample pushed at cycle 0 appears as CMD_OUT=01 at cycle 2. Throughput is one word per 4 cycles minimum.
- Reset mid-operation: an in-flight command is abandoned and CMD_OUT drops to 00 immediately (async).

Test Plan:
- Reset, push 3 samples 16'h1111/2222/3333 with READY=1 and WR_DONE 2 cycles after each acceptance -> three writes at COL 0,1,2 in order; WORDS_WRITTEN=3; CMD_OUT=01 exactly one cycle each.
- FRAME_START with TIMESTAMP=24'h123456, then sample 16'hBEEF -> writes 16'hA512, 16'h3456, 16'hBEEF at consecutive addresses.
- Hold READY=0 and push 9 samples -> SAMPLE_READY low after 8; OVERFLOW=1; CMD_OUT held at 01 with DATA_OUT=first sample; releasing READY drains all 8 in order.
- Preload address to col 511, row 0 -> next write at row 1, col 0. Preload to bank 3/row 8191/col 511 with WRAP_EN=0 -> FULL=1 and no further CMD_OUT=01. With WRAP_EN=1 -> next write at address 0.
- Assert NSYSRESET low during WAIT_DONE -> all outputs 0 asynchronously; after release the first write goes to address 0.
- Two FRAME_START pulses (TIMESTAMP 24'h000010, then 24'h000020) while READY=0 -> only one header, carrying 24'h000020.
